// File: rtl/cnn_fifo_pkg.sv
// Shared defaults, per-layer line depths and operation decode for the CNN line-buffer FIFO.
package cnn_fifo_pkg;

  localparam int CNN_FIFO_DATA_W    = 128;
  localparam int CNN_FIFO_MAX_DEPTH = 64;

  // Window overlap is 3 columns, so each layer's delay line is its row width minus 3.
  localparam int LAYER1_WIDTH = 64;
  localparam int LAYER2_WIDTH = 32;
  localparam int LAYER3_WIDTH = 16;
  localparam int LAYER4_WIDTH = 8;

  localparam int LAYER1_DEPTH = LAYER1_WIDTH - 3;
  localparam int LAYER2_DEPTH = LAYER2_WIDTH - 3;
  localparam int LAYER3_DEPTH = LAYER3_WIDTH - 3;
  localparam int LAYER4_DEPTH = LAYER4_WIDTH - 3;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_SHIFT = 2'd2
  } fifo_op_e;

  function automatic int layer_depth(input int layer);
    case (layer)
      1:       return LAYER1_DEPTH;
      2:       return LAYER2_DEPTH;
      3:       return LAYER3_DEPTH;
      4:       return LAYER4_DEPTH;
      default: return CNN_FIFO_MAX_DEPTH;
    endcase
  endfunction

endpackage

// File: rtl/cnn_fifo_mem.sv
// Line storage: one synchronous write port, one asynchronous read port at the same address.
module cnn_fifo_mem
  import cnn_fifo_pkg::*;
#(
  parameter int DATA_W = CNN_FIFO_DATA_W,
  parameter int DEPTH  = CNN_FIFO_MAX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the old word during a write, giving read-before-write at the slot.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/cnn_line_fifo.sv
// Stallable line-buffer delay FIFO with runtime depth, flush, fill count and output-valid qualifier.
module cnn_line_fifo
  import cnn_fifo_pkg::*;
#(
  parameter int DATA_W    = CNN_FIFO_DATA_W,
  parameter int MAX_DEPTH = CNN_FIFO_MAX_DEPTH,
  parameter int PTR_W     = $clog2(MAX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PTR_W:0]    cfg_depth,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [PTR_W:0]    fill_level,
  output logic              full
);

  localparam logic [PTR_W:0] MAX_D = (PTR_W + 1)'(MAX_DEPTH);
  localparam logic [PTR_W:0] ONE   = (PTR_W + 1)'(1);

  function automatic logic [PTR_W:0] clamp_depth(input logic [PTR_W:0] d);
    if (d == '0 || d > MAX_D) begin
      return MAX_D;
    end
    return d;
  endfunction

  fifo_op_e          op;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    depth_q;
  logic [PTR_W:0]    fill_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data_p1;
  logic              vld_p1;
  logic              at_depth;
  logic              ptr_wrap;
  logic              mem_we;

  always_comb begin
    op = OP_IDLE;
    if (clear) begin
      op = OP_CLEAR;
    end else if (shift_en) begin
      op = OP_SHIFT;
    end
  end

  assign at_depth = (fill_q == depth_q);
  assign ptr_wrap = ({1'b0, wr_ptr} == depth_q - ONE);
  assign mem_we   = !rst && (op == OP_SHIFT);

  cnn_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (wr_ptr),
    .wdata (in_data),
    .rdata (rd_data)
  );

  // Stage p1: evicted word and its one-cycle qualifier, registered with the line state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      fill_q      <= '0;
      depth_q     <= MAX_D;
      out_data_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      case (op)
        OP_CLEAR: begin
          wr_ptr      <= '0;
          fill_q      <= '0;
          depth_q     <= clamp_depth(cfg_depth);
          out_data_p1 <= '0;
          vld_p1      <= 1'b0;
        end
        OP_SHIFT: begin
          if (at_depth) begin
            out_data_p1 <= rd_data;
            vld_p1      <= 1'b1;
          end else begin
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
            fill_q      <= fill_q + ONE;
          end
          wr_ptr <= ptr_wrap ? '0 : wr_ptr + 1'b1;
        end
        default: begin
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign out_data   = out_data_p1;
  assign out_valid  = vld_p1;
  assign fill_level = fill_q;
  assign full       = at_depth;

endmodule

// File: doc/cnn_line_fifo.md
Name: cnn_line_fifo

Overview:
- Parametrised, stallable line-buffer delay FIFO for the CNN window-formation stages. It replaces the fixed-length, always-shifting per-layer delay chains.
- Delays a stream of feature-map words by a runtime-configured number of shifts (one image row minus window overlap), so one instance serves every layer width.
- Sits between a layer's output/weight-input stream and the window register array of the next convolution stage.
- Adds a shift enable (stall), a synchronous flush, a fill count and an output-valid qualifier.

Parameters:
- DATA_W, 128, width of one stored word (one layer input vector).
- MAX_DEPTH, 64, maximum delay length in words; must be ≥2.
- PTR_W, $clog2(MAX_DEPTH), pointer width (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- clear, input, 1, synchronous flush and depth reload for a new layer.
- cfg_depth, input, PTR_W+1, requested delay length; sampled only on clear.
- shift_en, input, 1, push in_data and advance the line by one word.
- in_data, input, DATA_W, word to push.
- out_data, output, DATA_W, word evicted by the last shift.
- out_valid, output, 1, one-cycle qualifier for out_data.
- fill_level, output, PTR_W+1, number of valid words held (0..depth).
- full, output, 1, fill_level == depth.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst). All state updates on the posedge clk only.
- Reset values:
  - out_data=0, out_valid=0, fill_level=0, full=0.
  - wr_ptr=0, depth_q=MAX_DEPTH.
  - Storage array is not reset; stale contents are never visible because output is gated by the fill count.
- Priority order: rst > clear > shift_en.
- clear:
  - wr_ptr←0, fill←0, out_valid←0, out_data←0.
  - depth_q←cfg_depth; if cfg_depth==0 or cfg_depth>MAX_DEPTH, depth_q←MAX_DEPTH (clamp).
  - An in_data presented in the same cycle as clear is discarded.
- shift_en=1 (and no rst/clear):
  - If fill==depth_q: out_data←mem[wr_ptr] (read-before-write), out_valid←1.
  - Otherwise: out_data←0, out_valid←0.
  - mem[wr_ptr]←in_data.
  - wr_ptr←(wr_ptr==depth_q-1) ? 0 : wr_ptr+1 (wrap at depth_q, not MAX_DEPTH).
  - fill←min(fill+1, depth_q).
- shift_en=0:
  - out_data holds its value; out_valid←0, so out_valid pulses once per qualifying shift.
  - No pointer or fill change.
- Latency:
  - The k-th word pushed (k≥1) appears on out_data with out_valid=1 in the cycle after the (k+depth_q)-th shift.
  - With shift_en tied high this is a pure depth_q+1-cycle pipeline delay, after depth_q warm-up shifts.
  - Stalls freeze the line without loss.
- Boundary conditions:
  - depth_q=1: every shift after the first evicts the immediately preceding word.
  - depth_q=MAX_DEPTH: the pointer uses the full range.
  - full stays asserted while the line is streaming; shifting when full is legal and is the steady state.
  - cfg_depth changes outside clear are ignored.
  - rst asserted mid-stream: all valid data is discarded next cycle; no out_valid pulse is produced.
- Width rules:
  - fill_level and cfg_depth are PTR_W+1 bits so that MAX_DEPTH is representable.
  - All comparisons are unsigned.

Decomposition:
- Package cnn_fifo_pkg holds:
  - CNN_FIFO_DATA_W and CNN_FIFO_MAX_DEPTH defaults.
  - Per-layer depth constants (LAYERn_WIDTH-3 for each layer), used by top-level instantiation and clear sequencing.
- Sub-module cnn_fifo_mem:
  - DATA_W × MAX_DEPTH array, one synchronous write port, one asynchronous read port addressed by wr_ptr.
  - Can be swapped for an SRAM macro with registered read, with a pointer-lookahead change in the parent only.

Test Plan:
1. rst, clear with cfg_depth=4, shift 10 words 0x1..0xA continuously -> out_valid first on the cycle after the 5th shift with out_data=0x1; then 0x2..0x6 on consecutive cycles; fill_level=4 and full=1 from the 4th shift on.
2. Same setup, shift_en low for 3 cycles after the 6th shift -> out_data holds 0x2 and out_valid=0 during the stall; resuming yields 0x3, no loss or duplication.
3. clear with cfg_depth=0, then cfg_depth=MAX_DEPTH+5 -> depth_q=MAX_DEPTH in both cases; first valid output after the MAX_DEPTH+1-th shift equals the first word pushed.
4. Mid-stream clear asserted together with shift_en and in_data=0xFF with cfg_depth=2 -> 0xFF dropped, fill=0; the next words 0x10, 0x11, 0x12 give first valid out_data=0x10 after the 3rd shift.
5. Synchronous rst asserted for 1 cycle while full and shifting -> the next cycle has out_valid=0, out_data=0, fill_level=0, depth_q=MAX_DEPTH; no asynchronous effect mid-cycle.
6. cfg_depth=1, random shift_en pattern, 200 words -> each valid out_data equals the previously pushed word (scoreboard against a queue model).
